lzd_rr_arbiter: RTL

//  Round-robin arbiter that shares one resource among `width` requesters.
//  - Priority runs MSB-first; bit width-1 is the highest fixed priority.
//  - The grant pick uses two LeadZeroDet instances: a masked pick and an unmasked fallback.
//  - It sits in front of shared arithmetic units (shared normalizer/LZD, multiplier) to sequence access.
//  - Registered one-hot grant; optional hold limit bounds burst length and prevents starvation.

---
 rtl/lzd_arb_pkg.sv | 30 +++
 rtl/LeadZeroDet.sv | 50 +++++
 rtl/lzd_arb_pick.sv | 31 +++
 rtl/lzd_rr_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/lzd_arb_pkg.sv
// Shared types and helpers for the LZD-based round-robin arbiter.
// Helpers work on a fixed wide vector; callers cast to their own width.
package lzd_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  localparam int MAXW = 64;

  // Ones strictly below bit j; j==0 means every requester is eligible again.
  function automatic logic [MAXW-1:0] below_mask(input int j, input int width);
    logic [MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < width) begin
        if (j == 0 || i < j) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic int onehot2bin(input logic [MAXW-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAXW; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/LeadZeroDet.sv
// One-hot of the most significant set bit of din (0 when din==0).
// The "any higher bit set" prefix-OR is built serially, Brent-Kung or Sklansky.
module LeadZeroDet #(
  parameter int width = 8,
  parameter int speed = 1
) (
  input  logic [width-1:0] din,
  output logic [width-1:0] onehot
);

  localparam int L = $clog2(width);

  // x is din bit-reversed so prefix index 0 is the MSB; y[k] = |x[0..k].
  logic [width-1:0] x;
  logic [width-1:0] y;

  always_comb begin
    x = '0;
    for (int k = 0; k < width; k++) x[k] = din[width-1-k];

    y = x;
    if (speed == 0) begin
      for (int k = 1; k < width; k++) y[k] = y[k] | y[k-1];
    end else if (speed == 1) begin
      for (int s = 0; s < L; s++) begin
        for (int k = (1 << s); k < width; k++) begin
          if (((k + 1) % (1 << (s + 1))) == 0) y[k] = y[k] | y[k - (1 << s)];
        end
      end
      for (int s = L - 2; s >= 0; s--) begin
        for (int k = (1 << s); k < width; k++) begin
          if ((((k + 1) % (1 << (s + 1))) == (1 << s)) && ((k + 1) > (1 << (s + 1))))
            y[k] = y[k] | y[k - (1 << s)];
        end
      end
    end else begin
      for (int s = 0; s < L; s++) begin
        for (int k = (1 << s); k < width; k++) begin
          if (((k >> s) & 1) == 1)
            y[k] = y[k] | y[((k >> (s + 1)) << (s + 1)) + (1 << s) - 1];
        end
      end
    end

    onehot = '0;
    onehot[width-1] = x[0];
    for (int k = 1; k < width; k++) onehot[width-1-k] = x[k] & ~y[k-1];
  end

endmodule

// File: rtl/lzd_arb_pick.sv
// Round-robin pick: highest requester inside the mask, else highest overall.
module lzd_arb_pick #(
  parameter int width = 8,
  parameter int speed = 1
) (
  input  logic [width-1:0] R,
  input  logic [width-1:0] M,
  output logic [width-1:0] P
);

  logic [width-1:0] rm;
  logic [width-1:0] p_masked;
  logic [width-1:0] p_full;

  assign rm = R & M;

  LeadZeroDet #(.width(width), .speed(speed)) u_lzd_masked (
    .din    (rm),
    .onehot (p_masked)
  );

  LeadZeroDet #(.width(width), .speed(speed)) u_lzd_full (
    .din    (R),
    .onehot (p_full)
  );

  always_comb begin
    P = (|rm) ? p_masked : p_full;
  end

endmodule

// File: rtl/lzd_rr_arbiter.sv
// MSB-first round-robin arbiter with registered one-hot grant and burst hold limit.
//   state | meaning
//   IDLE  | no grant outstanding, GNT==0
//   GRANT | GNT holds one requester; released on REQ drop or hold limit
module lzd_rr_arbiter
  import lzd_arb_pkg::*;
#(
  parameter int width   = 8,
  parameter int maxhold = 4,
  parameter int speed   = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [width-1:0]         REQ,
  output logic [width-1:0]         GNT,
  output logic [$clog2(width)-1:0] GIDX,
  output logic                     BUSY,
  output logic                     SWTCH
);

  localparam int IW = $clog2(width);
  localparam int HW = (maxhold == 0) ? 1 : $clog2(maxhold + 1);
  localparam logic [HW-1:0] HMAX = HW'(maxhold);

  arb_state_e      state_q, state_d;
  logic [width-1:0] gnt_q, gnt_d;
  logic [width-1:0] mask_q, mask_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic            swtch_q, swtch_d;

  logic [width-1:0] pick_init;
  logic [width-1:0] pick_rel;
  logic [width-1:0] others;
  logic [width-1:0] rel_req;
  logic [width-1:0] mask_n;
  logic [IW-1:0]    gidx;
  logic             rel;

  always_comb begin
    gidx    = IW'(onehot2bin(MAXW'(gnt_q)));
    mask_n  = width'(below_mask(int'(gidx), width));
    others  = REQ & ~gnt_q;
    // The current holder only competes again when nobody else is asking.
    rel_req = (|others) ? others : REQ;
    rel     = ~|(REQ & gnt_q) || ((maxhold != 0) && (hcnt_q == HMAX));
  end

  lzd_arb_pick #(.width(width), .speed(speed)) u_pick_init (
    .R (REQ),
    .M (mask_q),
    .P (pick_init)
  );

  lzd_arb_pick #(.width(width), .speed(speed)) u_pick_rel (
    .R (rel_req),
    .M (mask_n),
    .P (pick_rel)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      mask_q  <= '1;
      hcnt_q  <= '0;
      swtch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      hcnt_q  <= hcnt_d;
      swtch_q <= swtch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|REQ) state_d = GRANT;
      GRANT:   if (rel && (pick_rel == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d   = gnt_q;
    mask_d  = mask_q;
    hcnt_d  = hcnt_q;
    swtch_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|REQ) begin
          gnt_d  = pick_init;
          hcnt_d = HW'(1);
        end
      end
      GRANT: begin
        if (!rel) begin
          // Only reachable at all-ones when the hold limit is disabled.
          if (hcnt_q != '1) hcnt_d = hcnt_q + HW'(1);
        end else begin
          mask_d = mask_n;
          gnt_d  = pick_rel;
          if (|pick_rel) begin
            hcnt_d  = HW'(1);
            swtch_d = (pick_rel != gnt_q);
          end else begin
            hcnt_d  = '0;
          end
        end
      end
      default: begin
        gnt_d  = '0;
        hcnt_d = '0;
      end
    endcase
  end

  always_comb begin
    GNT   = gnt_q;
    GIDX  = gidx;
    BUSY  = |gnt_q;
    SWTCH = swtch_q;
  end

endmodule
